// File: rtl/fetch_sequencer.sv
// fetch_sequencer: pulses the program counter, fetches program memory at pc and
// hands each instruction word to the decoder over a valid/ready handshake.
module fetch_sequencer #(
  parameter int SIZE = 8,
  parameter int DATA_W = 16,
  parameter int MEM_LAT = 1,
  parameter int LAST_ADDR = 2**SIZE-1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE-1:0]   pc,
  output logic              incr,
  output logic [SIZE-1:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, HOLD = 3'd2, STEP = 3'd3, SETTLE = 3'd4, DONE = 3'd5;
  logic [2:0] state, nxt;
  logic [3:0] cnt;
  logic fetched, accept, last;
  assign mem_addr = pc;
  assign fetched = state == FETCH && cnt == 4'(MEM_LAT);
  assign accept = state == HOLD && instr_ready;
  assign last = pc == SIZE'(LAST_ADDR);
  always_comb
    nxt = state == IDLE   ? (start ? FETCH : IDLE) :
          state == FETCH  ? (fetched ? HOLD : FETCH) :
          state == HOLD   ? (accept ? (last ? DONE : STEP) : HOLD) :
          state == STEP   ? SETTLE :
          state == SETTLE ? FETCH :
          state == DONE   ? DONE : IDLE;
  // cnt idles at zero outside FETCH, so every entry into FETCH starts a fresh count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      instr <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == FETCH && !fetched) ? cnt + 4'd1 : 4'd0;
      if (fetched) instr <= mem_data;
    end
  assign incr = state == STEP;
  assign instr_valid = state == HOLD;
  assign busy = state == FETCH || state == HOLD || state == STEP || state == SETTLE;
  assign done = state == DONE;
endmodule
